// File: rtl/contador_crescente.sv
// Modulo-MODULO up-counter with an enable prescaler, synchronous saturating load,
// same-cycle carry and a registered wrap pulse. Define CONTADOR_DISPLAY_EN to add a 7-segment output.
module contador_crescente #(
    parameter int WIDTH  = 3,
    parameter int MODULO = 8,
    parameter int DIV    = 1
) (
    input  logic             clk1,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             cout,
    output logic             tc
`ifdef CONTADOR_DISPLAY_EN
    ,
    output logic [6:0]       seg
`endif
);

    localparam int               PW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    P_LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] Q_LAST = WIDTH'(MODULO - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             tc_q, tc_d;
    logic             at_last;
    logic             step;

    // NOTE: every combinational output gets a default first so no path can infer a latch;
    // blocking assignments are correct here because this block holds no state.
    always_comb begin
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        at_last = (count_q == Q_LAST);
        step    = en & ~load & (pre_q == P_LAST);
        cout    = step & at_last;

        if (load) begin
            count_d = (d > Q_LAST) ? Q_LAST : d;
            pre_d   = '0;
        end else if (step) begin
            // The wrap test comes first, so the increment can never overflow WIDTH bits.
            count_d = at_last ? '0 : count_q + 1'b1;
            pre_d   = '0;
            tc_d    = at_last;
        end else if (en) begin
            pre_d   = pre_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk1 or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
        end
    end

    assign Q  = count_q;
    assign tc = tc_q;

`ifdef CONTADOR_DISPLAY_EN
    logic [3:0] nibble;
    logic [6:0] seg_q, seg_d;

    if (WIDTH >= 4) begin : g_nib_wide
        assign nibble = count_q[3:0];
    end else begin : g_nib_narrow
        assign nibble = {{(4 - WIDTH){1'b0}}, count_q};
    end

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        seg_d = hex_to_seg(nibble);
    end

    // Decoding the current count and registering it puts seg one cycle behind Q.
    always_ff @(posedge clk1 or negedge clr) begin
        if (!clr) begin
            seg_q <= 7'h7F;
        end else begin
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_contador_crescente.sv
// Scoreboard bench for contador_crescente: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them. Covers default, MODULO=6/DIV=3 and a cascaded pair.
module tb_contador_crescente;

    logic clk1 = 1'b0;
    logic clr  = 1'b0;
    always #5 clk1 = ~clk1;

`ifdef CONTADOR_DISPLAY_EN
    localparam bit HAS_SEG = 1'b1;
`else
    localparam bit HAS_SEG = 1'b0;
`endif

    // u0: defaults
    logic       en0 = 1'b0, load0 = 1'b0;
    logic [2:0] d0 = '0, q0;
    logic       cout0, tc0;
    logic [6:0] seg0;

    // u1: MODULO=6, DIV=3
    logic       en1 = 1'b0, load1 = 1'b0;
    logic [2:0] d1 = '0, q1;
    logic       cout1, tc1;
    logic [6:0] seg1;

    // cascade: ua.cout drives ub.en
    logic       enc = 1'b0;
    logic       load_c = 1'b0;
    logic [2:0] d_c = '0;
    logic [2:0] qa, qb;
    logic       cout_a, cout_b, tc_a, tc_b;
    logic [6:0] seg_a, seg_b;

    contador_crescente #(.WIDTH(3), .MODULO(8), .DIV(1)) u0 (
        .clk1(clk1), .clr(clr), .en(en0), .load(load0), .d(d0),
        .Q(q0), .cout(cout0), .tc(tc0)
`ifdef CONTADOR_DISPLAY_EN
        , .seg(seg0)
`endif
    );

    contador_crescente #(.WIDTH(3), .MODULO(6), .DIV(3)) u1 (
        .clk1(clk1), .clr(clr), .en(en1), .load(load1), .d(d1),
        .Q(q1), .cout(cout1), .tc(tc1)
`ifdef CONTADOR_DISPLAY_EN
        , .seg(seg1)
`endif
    );

    contador_crescente #(.WIDTH(3), .MODULO(8), .DIV(1)) ua (
        .clk1(clk1), .clr(clr), .en(enc), .load(load_c), .d(d_c),
        .Q(qa), .cout(cout_a), .tc(tc_a)
`ifdef CONTADOR_DISPLAY_EN
        , .seg(seg_a)
`endif
    );

    contador_crescente #(.WIDTH(3), .MODULO(8), .DIV(1)) ub (
        .clk1(clk1), .clr(clr), .en(cout_a), .load(load_c), .d(d_c),
        .Q(qb), .cout(cout_b), .tc(tc_b)
`ifdef CONTADOR_DISPLAY_EN
        , .seg(seg_b)
`endif
    );

    typedef struct {
        int         id;
        logic [7:0] q;
        logic       cout;
        logic       tc;
        logic       chk_seg;
        logic [6:0] seg;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic expect_st(input int id, input int q, input bit c, input bit t, input string name);
        exp_t e;
        e.id = id; e.q = 8'(q); e.cout = c; e.tc = t;
        e.chk_seg = 1'b0; e.seg = '0; e.name = name;
        sb.push_back(e);
    endtask

    task automatic expect_seg(input int id, input int q, input bit c, input bit t,
                              input logic [6:0] s, input string name);
        exp_t e;
        e.id = id; e.q = 8'(q); e.cout = c; e.tc = t;
        e.chk_seg = HAS_SEG; e.seg = s; e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: compare everything queued for this cycle, half a period after the edge.
    always @(negedge clk1) begin
        while (sb.size() > 0) begin
            exp_t       e;
            logic [7:0] aq;
            logic       ac, at;
            logic [6:0] as;
            e = sb.pop_front();
            case (e.id)
                0:       begin aq = {5'b0, q0}; ac = cout0;  at = tc0;  as = seg0; end
                1:       begin aq = {5'b0, q1}; ac = cout1;  at = tc1;  as = seg1; end
                default: begin aq = {2'b0, qb, qa}; ac = cout_a; at = tc_b; as = seg_a; end
            endcase
            check({e.name, ".Q"},    16'(aq), 16'(e.q));
            check({e.name, ".cout"}, 16'(ac), 16'(e.cout));
            check({e.name, ".tc"},   16'(at), 16'(e.tc));
            if (e.chk_seg) check({e.name, ".seg"}, 16'(as), 16'(e.seg));
        end
    end

    initial begin
        // Power-on reset.
        tick();
        expect_seg(0, 0, 0, 0, 7'h7F, "rst_u0");
        expect_st(1, 0, 0, 0, "rst_u1");
        expect_st(3, 0, 0, 0, "rst_cas");
        tick();
        clr = 1'b1;

        // Default counter: 9 enabled edges from 0, plus one more.
        tick();
        en0 = 1'b1;
        expect_st(0, 0, 0, 0, "cnt8");
        for (int k = 1; k <= 9; k++) begin
            tick();
            expect_st(0, k % 8, (k % 8) == 7, k == 8, "cnt8");
        end
        tick();
        en0 = 1'b0;
        expect_st(0, 2, 0, 0, "cnt8_stop");

        // Load with en at Q=7: load wins, no carry, no tc.
        tick();
        en0 = 1'b1;
        expect_st(0, 2, 0, 0, "ld_pre");
        for (int v = 3; v <= 6; v++) begin
            tick();
            expect_st(0, v, 0, 0, "ld_pre");
        end
        tick();
        load0 = 1'b1;
        d0    = 3'd3;
        expect_st(0, 7, 0, 0, "ld_at7");
        tick();
        load0 = 1'b0;
        en0   = 1'b0;
        expect_st(0, 3, 0, 0, "ld_res");

        // Asynchronous reset right after the edge that moves Q 4->5, then display sequence.
        tick();
        en0 = 1'b1;
        expect_st(0, 3, 0, 0, "arst_pre");
        tick();
        expect_st(0, 4, 0, 0, "arst_pre");
        tick();
        clr = 1'b0;
        expect_seg(0, 0, 0, 0, 7'h7F, "arst");
        tick();
        expect_seg(0, 0, 0, 0, 7'h7F, "arst_hold");
        tick();
        clr = 1'b1;
        expect_seg(0, 0, 0, 0, 7'h7F, "arst_rel");
        tick();
        expect_seg(0, 1, 0, 0, 7'h40, "seg0");
        tick();
        en0 = 1'b0;
        expect_seg(0, 2, 0, 0, 7'h79, "seg1");
        tick();
        expect_st(0, 2, 0, 0, "idle_u0");

        // MODULO=6, DIV=3: Q = (e/3) mod 6 after e enabled edges.
        tick();
        en1 = 1'b1;
        expect_st(1, 0, 0, 0, "div3");
        for (int e = 1; e <= 18; e++) begin
            tick();
            expect_st(1, (e / 3) % 6, (e % 3 == 2) && ((e / 3) % 6 == 5), e == 18, "div3");
        end
        tick();
        en1 = 1'b0;
        expect_st(1, 0, 0, 0, "div3_off");
        tick();
        expect_st(1, 0, 0, 0, "div3_off");
        tick();
        en1 = 1'b1;
        expect_st(1, 0, 0, 0, "div3_on");
        tick();
        expect_st(1, 0, 0, 0, "div3_p2");
        tick();
        expect_st(1, 1, 0, 0, "div3_resume");

        // Saturating load (d=7 -> 5) also restarts the prescaler.
        tick();
        load1 = 1'b1;
        d1    = 3'd7;
        expect_st(1, 1, 0, 0, "sat_ld");
        tick();
        load1 = 1'b0;
        expect_st(1, 5, 0, 0, "sat_res");
        tick();
        expect_st(1, 5, 0, 0, "sat_p1");
        tick();
        expect_st(1, 5, 1, 0, "sat_p2");
        tick();
        en1 = 1'b0;
        expect_st(1, 0, 0, 1, "sat_wrap");
        tick();
        expect_st(1, 0, 0, 0, "sat_idle");

        // Cascaded pair: {B.Q, A.Q} counts 0..63 and wraps; B.tc pulses once.
        tick();
        enc = 1'b1;
        expect_st(3, 0, 0, 0, "cas");
        for (int e = 1; e <= 65; e++) begin
            tick();
            expect_st(3, e % 64, (e % 8) == 7, e == 64, "cas");
        end
        tick();
        enc = 1'b0;
        expect_st(3, 2, 0, 0, "cas_stop");

        repeat (3) @(negedge clk1);
        #1;
        check("sb_drain", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
